// File: rtl/display_source_scheduler.sv
// display_source_scheduler: shares one quad 7-segment display between four
// value producers. Rotates through valid sources on a fixed dwell time,
// supports a manual advance pulse, and lets a valid urgent source preempt.
module display_source_scheduler #(
    parameter int unsigned DWELL_CYCLES      = 54000000,
    parameter int unsigned URGENT_MIN_CYCLES = 27000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_number,
    input  logic [3:0]  src_colon,
    input  logic [3:0]  src_urgent,
    input  logic        next_req,
    output logic [15:0] disp_number,
    output logic        disp_colon,
    output logic        disp_blank,
    output logic [1:0]  active_src,
    output logic [3:0]  grant
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned HW = (URGENT_MIN_CYCLES > 1) ? $clog2(URGENT_MIN_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(URGENT_MIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        URGENT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    rot_src_q, rot_src_d;
    logic [1:0]    active_src_q, active_src_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   disp_number_q, disp_number_d;
    logic          disp_colon_q, disp_colon_d;
    logic          disp_blank_q, disp_blank_d;
    logic [3:0]    grant_q, grant_d;

    logic          search_found;
    logic [1:0]    search_idx;
    logic [1:0]    probe_idx;
    logic          urg_found;
    logic [1:0]    urg_idx;

    // Rotation search: first valid index after rot_src, wrapping back to rot_src itself
    always_comb begin
        search_found = 1'b0;
        search_idx   = rot_src_q;
        probe_idx    = rot_src_q;
        for (int unsigned k = 1; k < 5; k++) begin
            probe_idx = rot_src_q + 2'(k);
            if (!search_found && src_valid[probe_idx]) begin
                search_found = 1'b1;
                search_idx   = probe_idx;
            end
        end
    end

    // Urgent candidate: lowest index that is both urgent and valid
    always_comb begin
        urg_found = 1'b0;
        urg_idx   = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!urg_found && src_urgent[i] && src_valid[i]) begin
                urg_found = 1'b1;
                urg_idx   = 2'(i);
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d      = state_q;
        rot_src_d    = rot_src_q;
        active_src_d = active_src_q;
        dwell_d      = dwell_q;
        hold_d       = hold_q;

        unique case (state_q)
            IDLE: begin
                if (urg_found) begin
                    state_d      = URGENT;
                    active_src_d = urg_idx;
                    hold_d       = '0;
                end else if (search_found) begin
                    state_d      = SHOW;
                    rot_src_d    = search_idx;
                    active_src_d = search_idx;
                    dwell_d      = '0;
                end
            end
            SHOW: begin
                if (urg_found) begin
                    // rot_src keeps the preempted source so rotation resumes there
                    state_d      = URGENT;
                    active_src_d = urg_idx;
                    hold_d       = '0;
                end else if (!src_valid[active_src_q] || next_req || dwell_q == DWELL_LAST) begin
                    if (search_found) begin
                        rot_src_d    = search_idx;
                        active_src_d = search_idx;
                        dwell_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            URGENT: begin
                if (urg_found && urg_idx < active_src_q) begin
                    active_src_d = urg_idx;
                    hold_d       = '0;
                end else if (!src_valid[active_src_q] ||
                             (!src_urgent[active_src_q] && hold_q == HOLD_LAST)) begin
                    if (urg_found) begin
                        active_src_d = urg_idx;
                        hold_d       = '0;
                    end else if (src_valid[rot_src_q]) begin
                        state_d      = SHOW;
                        active_src_d = rot_src_q;
                        dwell_d      = '0;
                    end else if (search_found) begin
                        state_d      = SHOW;
                        rot_src_d    = search_idx;
                        active_src_d = search_idx;
                        dwell_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        disp_blank_d  = (state_d == IDLE);
        grant_d       = disp_blank_d ? 4'b0000 : (4'b0001 << active_src_d);
        disp_number_d = disp_blank_d ? 16'h0000 : src_number[{active_src_d, 4'b0000} +: 16];
        disp_colon_d  = disp_blank_d ? 1'b0 : src_colon[active_src_d];
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rot_src_q     <= 2'd3;
            active_src_q  <= 2'd0;
            dwell_q       <= '0;
            hold_q        <= '0;
            disp_number_q <= '0;
            disp_colon_q  <= 1'b0;
            disp_blank_q  <= 1'b1;
            grant_q       <= '0;
        end else begin
            state_q       <= state_d;
            rot_src_q     <= rot_src_d;
            active_src_q  <= active_src_d;
            dwell_q       <= dwell_d;
            hold_q        <= hold_d;
            disp_number_q <= disp_number_d;
            disp_colon_q  <= disp_colon_d;
            disp_blank_q  <= disp_blank_d;
            grant_q       <= grant_d;
        end
    end

    assign disp_number = disp_number_q;
    assign disp_colon  = disp_colon_q;
    assign disp_blank  = disp_blank_q;
    assign active_src  = active_src_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with short dwell/hold times.
module tb_display_source_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  src_valid;
    logic [63:0] src_number;
    logic [3:0]  src_colon;
    logic [3:0]  src_urgent;
    logic        next_req;
    logic [15:0] disp_number;
    logic        disp_colon;
    logic        disp_blank;
    logic [1:0]  active_src;
    logic [3:0]  grant;

    int tests;
    int failed;

    display_source_scheduler #(
        .DWELL_CYCLES      (8),
        .URGENT_MIN_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_number  (src_number),
        .src_colon   (src_colon),
        .src_urgent  (src_urgent),
        .next_req    (next_req),
        .disp_number (disp_number),
        .disp_colon  (disp_colon),
        .disp_blank  (disp_blank),
        .active_src  (active_src),
        .grant       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        tests++;
        assert (obs === expd) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] num_of(input int i);
        case (i)
            0:       return 16'h1111;
            1:       return 16'h2222;
            2:       return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    // Source 1 is the only one requesting the colon
    task automatic expect_show(input string tag, input int i);
        chk({tag, "_active"}, 32'(active_src), 32'(i));
        chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << i));
        chk({tag, "_number"}, 32'(disp_number), 32'(num_of(i)));
        chk({tag, "_blank"}, 32'(disp_blank), 32'd0);
        chk({tag, "_colon"}, 32'(disp_colon), (i == 1) ? 32'd1 : 32'd0);
    endtask

    task automatic expect_blank(input string tag);
        chk({tag, "_blank"}, 32'(disp_blank), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
    endtask

    task automatic expect_reset(input string tag);
        expect_blank(tag);
        chk({tag, "_number"}, 32'(disp_number), 32'd0);
        chk({tag, "_colon"}, 32'(disp_colon), 32'd0);
        chk({tag, "_active"}, 32'(active_src), 32'd0);
    endtask

    initial begin
        int rot_seq [4];
        tests      = 0;
        failed     = 0;
        rst        = 1'b1;
        src_valid  = 4'b0000;
        src_number = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        src_colon  = 4'b0010;
        src_urgent = 4'b0000;
        next_req   = 1'b0;
        rot_seq    = '{0, 1, 3, 0};

        // Reset values, then 20 idle cycles with nothing valid
        #1;
        expect_reset("reset");
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            expect_blank("idle");
            chk("idle_number", 32'(disp_number), 32'd0);
        end

        // Rotation 0,1,3,0 with 8 cycles each; source 2 invalid
        src_valid = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                expect_show("rot", rot_seq[s]);
            end
        end

        // Now src0 at dwell 7: expiry moves to src1, then next_req skips to src3 and src0
        step();
        chk("rot_wrap", 32'(active_src), 32'd1);
        next_req = 1'b1;
        step();
        next_req = 1'b0;
        expect_show("nreq_a", 3);
        next_req = 1'b1;
        step();
        next_req = 1'b0;
        expect_show("nreq_b", 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("pre_nreq", 32'(active_src), 32'd0);
        end

        // src0 at dwell 3: next_req advances to src1, which then gets a full 8 cycles
        next_req = 1'b1;
        step();
        next_req = 1'b0;
        expect_show("nreq_d3", 1);
        for (int c = 1; c < 8; c++) begin
            step();
            chk("full_dwell", 32'(active_src), 32'd1);
        end
        step();
        expect_show("after_full", 3);

        // next_req coincident with dwell expiry: single step src3 -> src0
        for (int c = 1; c < 8; c++) begin
            step();
            chk("pre_coinc", 32'(active_src), 32'd3);
        end
        next_req = 1'b1;
        step();
        next_req = 1'b0;
        expect_show("coinc", 0);
        step();
        chk("coinc_hold", 32'(active_src), 32'd0);

        // src0 at dwell 1 -> advance to dwell 5, then a one-cycle urgent on src2
        for (int c = 0; c < 4; c++) begin
            step();
            chk("pre_urg", 32'(active_src), 32'd0);
        end
        src_valid  = 4'b1111;
        src_urgent = 4'b0100;
        step();
        src_urgent = 4'b0000;
        expect_show("urg0", 2);
        for (int c = 1; c < 4; c++) begin
            step();
            chk("urg_hold", 32'(grant), 32'b0100);
        end
        step();
        expect_show("urg_exit", 0);
        for (int c = 1; c < 8; c++) begin
            step();
            chk("urg_resume", 32'(active_src), 32'd0);
        end
        step();
        expect_show("urg_next", 1);

        // Active src1 drops: src2 also invalid, so src3 follows
        src_valid = 4'b1001;
        step();
        expect_show("drop", 3);

        // Urgent on an invalid source is ignored
        src_urgent = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("urg_invalid", 32'(grant), 32'b1000);
        end
        src_urgent = 4'b0000;

        // All sources drop -> blank
        src_valid = 4'b0000;
        step();
        expect_blank("all_drop");
        step();
        expect_blank("all_drop_hold");

        // Asynchronous reset in the middle of an urgent hold
        src_valid  = 4'b0100;
        src_urgent = 4'b0100;
        step();
        expect_show("urg_idle", 2);
        step();
        #2;
        rst = 1'b1;
        #1;
        expect_reset("async_rst");
        src_valid  = 4'b1011;
        src_urgent = 4'b0000;
        step();
        expect_reset("rst_held");
        rst = 1'b0;
        step();
        expect_show("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
